// File: rtl/dsp48a1_pkg.sv
// Shared constants and types for the DSP48A1 MAC sequencer.
// Build option: DSP48_PREADD_EN sets the pre-adder enable bit in every opmode.
package dsp48a1_pkg;

   localparam int unsigned DSP_AW = 18;  // A/B/D operand width
   localparam int unsigned DSP_PW = 48;  // P accumulator width

   // X mux = M, Z mux = 0
   localparam logic [7:0] OPM_FIRST  = 8'h01;
   // X mux = M, Z mux = P
   localparam logic [7:0] OPM_ACC    = 8'h09;
   // X mux = 0, Z mux = P: keeps P while no operand is in flight
   localparam logic [7:0] OPM_HOLD   = 8'h08;
   localparam logic [7:0] OPM_PREADD = 8'h10;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDrain,
      StDone
   } seq_state_e;

   // Applies the build-time pre-adder selection to a base opmode.
   function automatic logic [7:0] opm_sel(input logic [7:0] base);
`ifdef DSP48_PREADD_EN
      return base | OPM_PREADD;
`else
      return base;
`endif
   endfunction

endpackage

// File: rtl/dsp48a1_lat_tracker.sv
// Follows issued operands through the slice pipeline. A valid tag and a
// batch-last tag shift one stage per cycle; the final stage lines up with the
// cycle in which the slice P/CARRYOUT outputs reflect that operand.
module dsp48a1_lat_tracker
   import dsp48a1_pkg::*;
#(
   parameter int unsigned LAT = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic issue_i,
   input  logic last_i,
   output logic p_valid_o,
   output logic drain_done_o
);

   logic [LAT-1:0] vld_q, vld_d;
   logic [LAT-1:0] last_q, last_d;

   // Next-state: shift both tag pipes by one stage.
   always_comb begin
      vld_d     = vld_q;
      last_d    = last_q;
      vld_d[0]  = issue_i;
      last_d[0] = issue_i && last_i;
      for (int unsigned i = 1; i < LAT; i++) begin
         vld_d[i]  = vld_q[i-1];
         last_d[i] = last_q[i-1];
      end
   end

   // Tag pipe registers; reset drops everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         last_q <= '0;
      end else begin
         vld_q  <= vld_d;
         last_q <= last_d;
      end
   end

   assign p_valid_o    = vld_q[LAT-1];
   assign drain_done_o = last_q[LAT-1];

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// Drives one DSP48A1 slice as a batch multiply-accumulate engine: operands in
// on a valid/ready stream, one 48-bit sum per batch out on a valid/ready port.
// Build option: DSP48_PREADD_EN registers s_d onto dsp_D and enables the
// slice pre-adder (product = (d + b) * a); otherwise dsp_D is tied to zero.
module dsp48a1_mac_sequencer
   import dsp48a1_pkg::*;
#(
   parameter int unsigned LAT        = 3,
   parameter int unsigned OPMODE_DLY = 1,
   parameter int unsigned MAX_LEN    = 256,
   parameter int unsigned CNT_W      = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DSP_AW-1:0] s_a,
   input  logic [DSP_AW-1:0] s_b,
   input  logic [DSP_AW-1:0] s_d,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DSP_PW-1:0] m_data,
   output logic              m_overflow,
   output logic [CNT_W-1:0]  m_count,
   output logic [DSP_AW-1:0] dsp_A,
   output logic [DSP_AW-1:0] dsp_B,
   output logic [DSP_AW-1:0] dsp_D,
   output logic [7:0]        dsp_OPMODE,
   output logic              dsp_CE,
   output logic              dsp_RST,
   input  logic [DSP_PW-1:0] dsp_P,
   input  logic              dsp_CARRYOUT
);

   seq_state_e                 state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
   logic [DSP_AW-1:0]          a_q, b_q;
   logic                       op_vld_q, op_last_q;
   logic [OPMODE_DLY-1:0][7:0] opm_q;
   logic [7:0]                 opm_in, opm_out_q;
   logic [1:0]                 rst_hold_q;
   logic [DSP_PW-1:0]          m_data_q;
   logic [CNT_W-1:0]           m_count_q;
   logic                       ovf_q, ovf_d;
   logic                       hs, batch_end, latch_res, res_taken;
   logic                       p_valid, drain_done;

   // Slice RST stays high two cycles past reset release so its sync regs flush.
   assign dsp_RST    = rst_hold_q[1];
   assign dsp_CE     = 1'b1;
   assign s_ready    = (state_q == StAccum) || ((state_q == StIdle) && !rst_hold_q[1]);
   assign m_valid    = (state_q == StDone);
   assign hs         = s_valid && s_ready;
   assign cnt_inc    = (state_q == StIdle) ? CNT_W'(1) : cnt_q + CNT_W'(1);
   assign batch_end  = s_last || (cnt_inc == CNT_W'(MAX_LEN));
   assign ovf_d      = res_taken ? 1'b0 : (ovf_q || (p_valid && dsp_CARRYOUT));
   assign dsp_A      = a_q;
   assign dsp_B      = b_q;
   assign dsp_OPMODE = opm_out_q;
   assign m_data     = m_data_q;
   assign m_count    = m_count_q;
   assign m_overflow = ovf_q;

   // Next-state and per-cycle opmode selection.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      opm_in    = opm_sel(OPM_HOLD);
      latch_res = 1'b0;
      res_taken = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hs) begin
               opm_in  = opm_sel(OPM_FIRST);
               cnt_d   = cnt_inc;
               state_d = batch_end ? StDrain : StAccum;
            end
         end
         StAccum: begin
            if (hs) begin
               opm_in = opm_sel(OPM_ACC);
               cnt_d  = cnt_inc;
               if (batch_end) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (drain_done) begin
               latch_res = 1'b1;
               state_d   = StDone;
            end
         end
         StDone: begin
            if (m_ready) begin
               res_taken = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, batch counter, sticky overflow and slice reset stretcher.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         rst_hold_q <= 2'b11;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         rst_hold_q <= {rst_hold_q[0], 1'b0};
      end
   end

   // Operand registers load only on handshake; tags mark what the slice holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         op_vld_q  <= 1'b0;
         op_last_q <= 1'b0;
      end else begin
         if (hs) begin
            a_q <= s_a;
            b_q <= s_b;
         end
         op_vld_q  <= hs;
         op_last_q <= hs && batch_end;
      end
   end

   // Opmode queue: opmode trails its operands so it meets the product at the M stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opm_q     <= '0;
         opm_out_q <= '0;
      end else begin
         opm_q[0] <= opm_in;
         for (int unsigned i = 1; i < OPMODE_DLY; i++) begin
            opm_q[i] <= opm_q[i-1];
         end
         opm_out_q <= opm_q[OPMODE_DLY-1];
      end
   end

   // Result capture once the batch's final product has reached P.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data_q  <= '0;
         m_count_q <= '0;
      end else if (latch_res) begin
         m_data_q  <= dsp_P;
         m_count_q <= cnt_q;
      end
   end

`ifdef DSP48_PREADD_EN
   logic [DSP_AW-1:0] d_q;

   // Pre-adder operand travels with A/B.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q <= '0;
      end else if (hs) begin
         d_q <= s_d;
      end
   end

   assign dsp_D = d_q;
`else
   logic unused_s_d;
   assign unused_s_d = ^s_d;
   assign dsp_D      = '0;
`endif

   dsp48a1_lat_tracker #(
      .LAT(LAT)
   ) u_lat_tracker (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_i     (op_vld_q),
      .last_i      (op_last_q),
      .p_valid_o   (p_valid),
      .drain_done_o(drain_done)
   );

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer driving a behavioural DSP48A1 slice
// (A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYOUTREG=1, sync RST).
module tb_dsp48a1_mac_sequencer;

   localparam int unsigned Lat    = 3;
   localparam int unsigned MaxLen = 256;
   localparam int unsigned CntW   = 9;
`ifdef DSP48_PREADD_EN
   localparam bit PreAdd = 1'b1;
`else
   localparam bit PreAdd = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [17:0]     s_a = '0, s_b = '0, s_d = '0;
   logic            s_last = 1'b0;
   logic            m_valid;
   logic            m_ready = 1'b0;
   logic [47:0]     m_data;
   logic            m_overflow;
   logic [CntW-1:0] m_count;
   logic [17:0]     dsp_A, dsp_B, dsp_D;
   logic [7:0]      dsp_OPMODE;
   logic            dsp_CE, dsp_RST;
   logic [47:0]     dsp_P;
   logic            dsp_CARRYOUT;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dsp48a1_mac_sequencer #(
      .LAT       (Lat),
      .OPMODE_DLY(1),
      .MAX_LEN   (MaxLen),
      .CNT_W     (CntW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_a         (s_a),
      .s_b         (s_b),
      .s_d         (s_d),
      .s_last      (s_last),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_overflow  (m_overflow),
      .m_count     (m_count),
      .dsp_A       (dsp_A),
      .dsp_B       (dsp_B),
      .dsp_D       (dsp_D),
      .dsp_OPMODE  (dsp_OPMODE),
      .dsp_CE      (dsp_CE),
      .dsp_RST     (dsp_RST),
      .dsp_P       (dsp_P),
      .dsp_CARRYOUT(dsp_CARRYOUT)
   );

   // Behavioural slice.
   logic signed [17:0] sl_a1, sl_b1;
   logic signed [35:0] sl_prod;
   logic [47:0]        sl_m, sl_p, sl_x, sl_z;
   logic [7:0]         sl_opm;
   logic               sl_co;
   logic [17:0]        sl_pre;
   logic [48:0]        sl_sum;

   assign sl_prod      = sl_a1 * sl_b1;
   assign dsp_P        = sl_p;
   assign dsp_CARRYOUT = sl_co;

   always_comb begin
      sl_pre = sl_opm[4] ? (dsp_D + dsp_B) : dsp_B;
      sl_x   = '0;
      sl_z   = '0;
      if (sl_opm[1:0] == 2'd1) sl_x = sl_m;
      if (sl_opm[1:0] == 2'd2) sl_x = sl_p;
      if (sl_opm[3:2] == 2'd2) sl_z = sl_p;
      sl_sum = {1'b0, sl_z} + {1'b0, sl_x};
   end

   always @(posedge clk) begin
      if (dsp_RST) begin
         sl_a1 <= '0; sl_b1 <= '0; sl_m <= '0; sl_opm <= '0; sl_p <= '0; sl_co <= 1'b0;
      end else if (dsp_CE) begin
         sl_a1  <= dsp_A;
         sl_b1  <= sl_pre;
         sl_m   <= {{12{sl_prod[35]}}, sl_prod};
         sl_opm <= dsp_OPMODE;
         sl_p   <= sl_sum[47:0];
         sl_co  <= sl_sum[48];
      end
   end

   // Reference product: signed 18x18 (optionally pre-added), wrapped to 48 bits.
   function automatic logic [47:0] prod_of(input logic [17:0] a, input logic [17:0] b,
                                           input logic [17:0] d);
      logic signed [17:0] sa, sb;
      longint p;
      logic [63:0] pu;
      sa = a;
      sb = b + (PreAdd ? d : 18'd0);
      p  = longint'(sa) * longint'(sb);
      pu = p;
      return pu[47:0];
   endfunction

   task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                       input logic last, output bit ok, output int unsigned hcyc);
      ok = 1'b0; hcyc = 0;
      s_valid = 1'b1; s_a = a; s_b = b; s_d = d; s_last = last;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (s_ready === 1'b1) begin
            @(posedge clk); #1;
            hcyc = cyc; ok = 1'b1;
            break;
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic get_result(input int unsigned hold, output bit ok, output logic [47:0] data,
                             output logic ovf, output logic [CntW-1:0] cnt,
                             output int unsigned vcyc);
      ok = 1'b0; data = '0; ovf = 1'b0; cnt = '0; vcyc = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (m_valid === 1'b1) begin
            ok = 1'b1; vcyc = cyc; data = m_data; ovf = m_overflow; cnt = m_count;
            break;
         end
      end
      if (ok) begin
         repeat (hold) @(negedge clk);
         m_ready = 1'b1;
         @(posedge clk); #1;
         m_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 48'd0 || m_overflow !== 1'b0 ||
          m_count !== '0) begin
         errors++;
         $display("FAIL reset_outputs: s_ready=%b m_valid=%b m_data=%0d ovf=%b cnt=%0d, want 0s",
                  s_ready, m_valid, m_data, m_overflow, m_count);
      end
      checks++;
      if (dsp_A !== 18'd0 || dsp_B !== 18'd0 || dsp_D !== 18'd0 || dsp_OPMODE !== 8'd0 ||
          dsp_CE !== 1'b1 || dsp_RST !== 1'b1) begin
         errors++;
         $display("FAIL reset_dsp: A=%h B=%h D=%h OPM=%h CE=%b RST=%b, want 0,0,0,0,1,1",
                  dsp_A, dsp_B, dsp_D, dsp_OPMODE, dsp_CE, dsp_RST);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (dsp_RST !== 1'b1 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold1: RST=%b s_ready=%b, want 1,0", dsp_RST, s_ready);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (dsp_RST !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_hold2: RST=%b s_ready=%b, want 0,1", dsp_RST, s_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      bit ok, all_ok;
      int unsigned h, v;
      logic [47:0] dat;
      logic ovf;
      logic [CntW-1:0] cnt;
      all_ok = 1'b1;
      send(18'd3, 18'd4, 18'd0, 1'b0, ok, h); all_ok &= ok;
      send(18'd5, 18'd6, 18'd0, 1'b0, ok, h); all_ok &= ok;
      send(18'd7, 18'd8, 18'd0, 1'b1, ok, h); all_ok &= ok;
      get_result(0, ok, dat, ovf, cnt, v); all_ok &= ok;
      checks++;
      if (all_ok !== 1'b1) begin errors++; $display("FAIL basic_handshake: got %b want 1", all_ok); end
      checks++;
      if (dat !== 48'd98 || cnt !== CntW'(3) || ovf !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: data=%0d cnt=%0d ovf=%b, want 98,3,0", dat, cnt, ovf);
      end
      checks++;
      if (v - h !== Lat + 1) begin
         errors++;
         $display("FAIL basic_latency: got %0d cycles want %0d", v - h, Lat + 1);
      end
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_after_ack: m_valid=%b s_ready=%b, want 0,1", m_valid, s_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      bit ok, all_ok;
      int unsigned h, v;
      logic [47:0] dat;
      logic ovf;
      logic [CntW-1:0] cnt;
      send(18'd1000, 18'd2000, 18'd0, 1'b1, ok, h); all_ok = ok;
      get_result(0, ok, dat, ovf, cnt, v); all_ok &= ok;
      checks++;
      if (all_ok !== 1'b1 || dat !== 48'd2_000_000 || cnt !== CntW'(1) || v - h !== Lat + 1) begin
         errors++;
         $display("FAIL single: ok=%b data=%0d cnt=%0d lat=%0d, want 1,2000000,1,%0d",
                  all_ok, dat, cnt, v - h, Lat + 1);
      end
   endtask

   task automatic test_bubbles();
      bit ok, all_ok;
      int unsigned h, v;
      logic [47:0] dat;
      logic ovf;
      logic [CntW-1:0] cnt;
      send(18'd2, 18'd3, 18'd0, 1'b0, ok, h); all_ok = ok;
      repeat (4) @(posedge clk); #1;
      send(18'd4, 18'd5, 18'd0, 1'b1, ok, h); all_ok &= ok;
      get_result(0, ok, dat, ovf, cnt, v); all_ok &= ok;
      checks++;
      if (all_ok !== 1'b1 || dat !== 48'd26 || cnt !== CntW'(2)) begin
         errors++;
         $display("FAIL bubbles: ok=%b data=%0d cnt=%0d, want 1,26,2", all_ok, dat, cnt);
      end
   endtask

   task automatic test_backpressure();
      bit ok, seen;
      int unsigned h;
      send(18'd10, 18'd10, 18'd0, 1'b1, ok, h);
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (m_valid === 1'b1) begin seen = 1'b1; break; end
      end
      checks++;
      if (!(ok && seen)) begin errors++; $display("FAIL bp_valid: ok=%b seen=%b want 1,1", ok, seen); end
      s_valid = 1'b1; s_a = 18'd9; s_b = 18'd9; s_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (m_valid !== 1'b1 || m_data !== 48'd100 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall%0d: m_valid=%b data=%0d s_ready=%b, want 1,100,0",
                     i, m_valid, m_data, s_ready);
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      m_ready = 1'b1;
      @(posedge clk); #1 m_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_release: m_valid=%b want 0", m_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      bit ok, all_ok;
      int unsigned h, v;
      logic [47:0] dat;
      logic ovf;
      logic [CntW-1:0] cnt;
      send(18'h3FFFF, 18'd1, 18'd0, 1'b0, ok, h); all_ok = ok;
      send(18'd1, 18'd1, 18'd0, 1'b1, ok, h); all_ok &= ok;
      get_result(2, ok, dat, ovf, cnt, v); all_ok &= ok;
      checks++;
      if (all_ok !== 1'b1 || dat !== 48'd0 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL overflow: ok=%b data=%0d ovf=%b, want 1,0,1", all_ok, dat, ovf);
      end
      @(negedge clk);
      checks++;
      if (m_overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b want 0", m_overflow); end
      @(posedge clk); #1;
   endtask

   task automatic test_preadd();
      bit ok, all_ok;
      int unsigned h, v;
      logic [47:0] dat, exp;
      logic ovf;
      logic [CntW-1:0] cnt;
      exp = PreAdd ? 48'd300 : 48'd100;
      send(18'd2, 18'd50, 18'd100, 1'b1, ok, h); all_ok = ok;
      get_result(0, ok, dat, ovf, cnt, v); all_ok &= ok;
      checks++;
      if (all_ok !== 1'b1 || dat !== exp) begin
         errors++;
         $display("FAIL preadd: ok=%b data=%0d, want 1,%0d", all_ok, dat, exp);
      end
   endtask

   task automatic test_max_len();
      bit ok, all_ok;
      int unsigned h, v;
      logic [47:0] dat;
      logic ovf;
      logic [CntW-1:0] cnt;
      all_ok = 1'b1;
      for (int i = 0; i < MaxLen; i++) begin
         send(18'(i + 1), 18'd2, 18'd0, 1'b0, ok, h); all_ok &= ok;
      end
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL maxlen_stop: s_ready=%b want 0", s_ready); end
      get_result(0, ok, dat, ovf, cnt, v); all_ok &= ok;
      checks++;
      if (all_ok !== 1'b1 || dat !== 48'd65792 || cnt !== CntW'(MaxLen) || v - h !== Lat + 1) begin
         errors++;
         $display("FAIL maxlen: ok=%b data=%0d cnt=%0d lat=%0d, want 1,65792,%0d,%0d",
                  all_ok, dat, cnt, v - h, MaxLen, Lat + 1);
      end
   endtask

   task automatic test_midreset();
      bit ok, all_ok;
      int unsigned h, v;
      logic [47:0] dat;
      logic ovf;
      logic [CntW-1:0] cnt;
      send(18'd5, 18'd7, 18'd0, 1'b0, ok, h); all_ok = ok;
      send(18'd6, 18'd8, 18'd0, 1'b0, ok, h); all_ok &= ok;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0 || dsp_RST !== 1'b1 || dsp_A !== 18'd0) begin
         errors++;
         $display("FAIL midreset_abort: m_valid=%b s_ready=%b RST=%b A=%0d, want 0,0,1,0",
                  m_valid, s_ready, dsp_RST, dsp_A);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      send(18'd1, 18'd1, 18'd0, 1'b1, ok, h); all_ok &= ok;
      get_result(0, ok, dat, ovf, cnt, v); all_ok &= ok;
      checks++;
      if (all_ok !== 1'b1 || dat !== 48'd1 || cnt !== CntW'(1) || ovf !== 1'b0) begin
         errors++;
         $display("FAIL midreset_next: ok=%b data=%0d cnt=%0d ovf=%b, want 1,1,1,0",
                  all_ok, dat, cnt, ovf);
      end
   endtask

   task automatic test_random();
      bit ok, all_ok;
      int unsigned h, v, len;
      logic [47:0] dat, exp_sum, p;
      logic [48:0] t;
      logic ovf, exp_ovf;
      logic [CntW-1:0] cnt;
      logic [17:0] ra, rb, rd;
      for (int n = 0; n < 12; n++) begin
         len = $urandom_range(1, 6);
         all_ok = 1'b1; exp_sum = '0; exp_ovf = 1'b0;
         for (int i = 0; i < int'(len); i++) begin
            ra = 18'($urandom); rb = 18'($urandom); rd = 18'($urandom);
            p = prod_of(ra, rb, rd);
            if (i == 0) begin
               exp_sum = p;
            end else begin
               t = {1'b0, exp_sum} + {1'b0, p};
               exp_sum = t[47:0];
               exp_ovf = exp_ovf | t[48];
            end
            send(ra, rb, rd, i == int'(len) - 1, ok, h); all_ok &= ok;
            if (i != int'(len) - 1 && $urandom_range(0, 2) == 0) begin
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
         end
         get_result($urandom_range(0, 3), ok, dat, ovf, cnt, v); all_ok &= ok;
         checks++;
         if (all_ok !== 1'b1 || dat !== exp_sum || ovf !== exp_ovf || cnt !== CntW'(len) ||
             v - h !== Lat + 1) begin
            errors++;
            $display("FAIL random%0d: ok=%b data=%h ovf=%b cnt=%0d lat=%0d, want 1,%h,%b,%0d,%0d",
                     n, all_ok, dat, ovf, cnt, v - h, exp_sum, exp_ovf, len, Lat + 1);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_bubbles();
      test_backpressure();
      test_overflow();
      test_preadd();
      test_max_len();
      test_midreset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
